// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: datapath width, PC-select encodings and fetch FSM states.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    PS_INC     = 2'b00,
    PS_INC_ALT = 2'b01,
    PS_BR      = 2'b10,
    PS_CBR     = 2'b11
  } ps_e;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_EXEC
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_data
  );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: sequential, register branch or PC-relative word offset, all modulo 2^64.
module next_pc_logic
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      ps,
  input  logic [XLEN-1:0] k,
  input  logic [XLEN-1:0] reg_a,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] k_words;

  assign pc_plus4 = pc + FOUR;
  assign k_words  = {k[XLEN-3:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (ps_e'(ps))
      PS_INC, PS_INC_ALT: next_pc = pc_plus4;
      PS_BR:              next_pc = reg_a;
      PS_CBR:             next_pc = pc + k_words;
      default:            next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: request/wait/execute sequencer owning the PC, latched instruction and retire counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     COUNT_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         ps,
  input  logic [XLEN-1:0]    k,
  input  logic [XLEN-1:0]    reg_a,
  input  logic               ns,
  input  logic               stall,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic [COUNT_W-1:0] retired
);

  fetch_state_e       state, state_n;
  logic [XLEN-1:0]    pc_n, next_pc;
  logic [INSTR_W-1:0] instr_n;
  logic               second, second_n;
  logic               retire;

  next_pc_logic u_next_pc (
    .pc       (pc),
    .ps       (ps),
    .k        (k),
    .reg_a    (reg_a),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // Request is gated by reset so nothing is issued while the unit is held.
  assign imem.imem_req  = (state == ST_REQ) && !reset;
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == ST_EXEC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instruction <= '0;
      second      <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instr_n;
      second      <= second_n;
      if (retire) retired <= retired + COUNT_W'(1);
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instruction;
    second_n = second;
    retire   = 1'b0;
    case (state)
      ST_REQ: begin
        if (imem.imem_ready) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imem_valid) begin
          instr_n = imem.imem_data;
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Stall wins over ns; once the second cycle is used, ns is treated as 0.
        if (!stall) begin
          if (ns && !second) begin
            second_n = 1'b1;
          end else begin
            pc_n     = next_pc;
            second_n = 1'b0;
            retire   = 1'b1;
            state_n  = ST_REQ;
          end
        end
      end
      default: state_n = ST_REQ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned     CW  = 4;
  localparam logic [63:0]     RPC = 64'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ps;
  logic [63:0] k, reg_a;
  logic        ns, stall;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc, pc_plus4;
  logic [CW-1:0] retired;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RPC), .COUNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .ps          (ps),
    .k           (k),
    .reg_a       (reg_a),
    .ns          (ns),
    .stall       (stall),
    .imem        (imem),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] exp_pc;
  logic [31:0] exp_instr;
  int unsigned exp_ret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory side: accept the request (randomly delayed unless fast), injecting stray responses.
  task automatic fetch_req(input bit fast);
    bit acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) begin
      check("imem_req", imem.imem_req, 1);
      check("imem_addr", imem.imem_addr, exp_pc);
      check("instr_valid_req", instr_valid, 0);
      imem.imem_ready = (fast || i >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      imem.imem_valid = fast ? 1'b0 : 1'($urandom_range(0, 1));
      imem.imem_data  = $urandom;
      acc = imem.imem_ready;
      tick();
    end
    imem.imem_ready = 1'b0;
    imem.imem_valid = 1'b0;
    check("imem_req_wait", imem.imem_req, 0);
  endtask

  task automatic fetch_data(input bit fast, input logic [31:0] data);
    int unsigned n = fast ? 0 : $urandom_range(0, 3);
    for (int i = 0; i < int'(n); i++) begin
      imem.imem_ready = 1'($urandom_range(0, 1));
      tick();
      check("instr_valid_wait", instr_valid, 0);
      check("imem_req_wait", imem.imem_req, 0);
    end
    imem.imem_ready = 1'b0;
    imem.imem_valid = 1'b1;
    imem.imem_data  = data;
    tick();
    imem.imem_valid = 1'b0;
    imem.imem_data  = $urandom;
    exp_instr = data;
  endtask

  // Control-unit side: drive ns/stall per execute cycle; the model counts cycles from the rules.
  task automatic execute(input logic [1:0] p, input logic [63:0] kk, input logic [63:0] ra,
                         input bit rnd, input logic [7:0] stall_pat, input logic [7:0] ns_pat,
                         output int unsigned ncyc);
    bit used = 1'b0;
    bit done = 1'b0;
    ncyc = 0;
    ps = p; k = kk; reg_a = ra;
    while (!done) begin
      check("instr_valid_exec", instr_valid, 1);
      check("instruction", instruction, exp_instr);
      check("pc_exec", pc, exp_pc);
      check("pc_plus4", pc_plus4, exp_pc + 64'd4);
      if (rnd) begin
        stall = (ncyc < 8) && ($urandom_range(0, 2) == 0);
        ns    = 1'($urandom_range(0, 1));
      end else begin
        stall = (ncyc < 8) ? stall_pat[ncyc[2:0]] : 1'b0;
        ns    = (ncyc < 8) ? ns_pat[ncyc[2:0]] : 1'b0;
      end
      if (!stall) begin
        if (ns && !used) used = 1'b1;
        else done = 1'b1;
      end
      ncyc++;
      tick();
    end
    stall = 1'b0; ns = 1'b0;
    ps = 2'($urandom); k = {$urandom, $urandom}; reg_a = {$urandom, $urandom};
    case (p)
      2'b10:   exp_pc = ra;
      2'b11:   exp_pc = exp_pc + kk * 64'd4;
      default: exp_pc = exp_pc + 64'd4;
    endcase
    exp_ret++;
    check("instr_valid_done", instr_valid, 0);
    check("retired", retired, 64'(exp_ret % (1 << CW)));
    check("pc_next", pc, exp_pc);
  endtask

  initial begin
    int unsigned nc;
    logic [1:0]  p;
    logic [11:0] r;
    logic [63:0] kk, ra;

    reset = 1'b1; ps = 2'b00; k = '0; reg_a = '0; ns = 1'b0; stall = 1'b0;
    imem.imem_ready = 1'b0; imem.imem_valid = 1'b0; imem.imem_data = '0;
    exp_pc = RPC; exp_ret = 0; exp_instr = '0;
    tick();
    imem.imem_ready = 1'b1; imem.imem_valid = 1'b1; imem.imem_data = 32'hDEADBEEF;
    tick();
    check("rst_imem_req", imem.imem_req, 0);
    check("rst_pc", pc, RPC);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_retired", retired, 0);
    check("rst_instruction", instruction, 0);
    imem.imem_ready = 1'b0; imem.imem_valid = 1'b0;
    reset = 1'b0;
    #1;

    // First fetch at minimum latency, then a sequential run.
    fetch_req(1'b1);
    fetch_data(1'b1, 32'h8B020020);
    check("first_instruction", instruction, 32'h8B020020);
    execute(2'b01, '0, '0, 1'b0, 8'h00, 8'h00, nc);
    check("ncyc_single", nc, 1);
    for (int i = 0; i < 3; i++) begin
      fetch_req(1'b0);
      fetch_data(1'b0, $urandom);
      execute(2'b01, '0, '0, 1'b0, 8'h00, 8'h00, nc);
    end
    check("pc16", pc, 64'd16);

    // Relative and register branches.
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, '0, 1'b0, 8'h00, 8'h00, nc);
    check("cbr_target", pc, 64'd8);
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b10, '0, 64'h100, 1'b0, 8'h00, 8'h00, nc);
    check("br_target", pc, 64'h100);

    // Second execute cycle and stall interaction.
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b01, '0, '0, 1'b0, 8'h00, 8'h01, nc);
    check("ncyc_ns_pulse", nc, 2);
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b01, '0, '0, 1'b0, 8'h00, 8'hFF, nc);
    check("ncyc_ns_held", nc, 2);
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b00, '0, '0, 1'b0, 8'h07, 8'h01, nc);
    check("ncyc_stall", nc, 4);

    // PC wrap at the top of the address space.
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b10, '0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 8'h00, 8'h00, nc);
    fetch_req(1'b0); fetch_data(1'b0, $urandom);
    execute(2'b01, '0, '0, 1'b0, 8'h00, 8'h00, nc);
    check("pc_wrap", pc, 64'd0);

    // Reset while a fetch is outstanding.
    fetch_req(1'b0);
    reset = 1'b1;
    #1;
    check("midrst_imem_req", imem.imem_req, 0);
    check("midrst_pc", pc, RPC);
    check("midrst_instr_valid", instr_valid, 0);
    check("midrst_retired", retired, 0);
    check("midrst_instruction", instruction, 0);
    imem.imem_valid = 1'b1; imem.imem_data = 32'hCAFEF00D;
    tick();
    imem.imem_valid = 1'b0;
    reset = 1'b0;
    #1;
    exp_pc = RPC; exp_ret = 0;
    check("post_rst_instr_valid", instr_valid, 0);

    // Randomized instruction stream; long enough to wrap the narrow retire counter.
    for (int i = 0; i < 40; i++) begin
      fetch_req(1'b0);
      fetch_data(1'b0, $urandom);
      p  = 2'($urandom_range(0, 3));
      r  = 12'($urandom);
      kk = {{52{r[11]}}, r};
      ra = {$urandom, $urandom};
      execute(p, kk, ra, 1'b1, 8'h00, 8'h00, nc);
    end
    fetch_req(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Parameter COUNT_W, default 32, SHALL be the width of the retired-instruction counter.
REQ-003 Port clock  input  1  SHALL be the rising-edge clock; reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port ps  input  2  SHALL be the PC-select field of the current control word.
REQ-005 Port k  input  64  SHALL be the constant field of the control word, already sign-extended by the control unit.
REQ-006 Port reg_a  input  64  SHALL be the register-file A-bus value, used as the BR target.
REQ-007 Port ns  input  1  SHALL be the control-word next-state bit, which requests a second execute cycle.
REQ-008 Port stall  input  1  SHALL be a datapath stall that holds the execute stage.
REQ-009 Port imem_req  output  1  SHALL be the instruction-memory request valid signal.
REQ-010 Port imem_addr  output  64  SHALL be the fetch address.
REQ-011 Port imem_ready  input  1  SHALL be the memory request-accept signal.
REQ-012 Port imem_valid  input  1  SHALL be the response valid signal; imem_data  input  32  SHALL be the instruction word.
REQ-013 Port instruction  output  32  SHALL be the latched instruction sent to the control unit.
REQ-014 Port instr_valid  output  1  SHALL mark that instruction as executing this cycle.
REQ-015 Port pc  output  64  SHALL be the current PC; pc_plus4  output  64  SHALL be pc+4, the BL link value.
REQ-016 Port retired  output  COUNT_W  SHALL be the count of completed instructions.

Function
REQ-017 The FSM SHALL have states REQ, WAIT and EXEC.
REQ-018 In REQ: imem_req=1 and imem_addr=pc; the FSM SHALL move to WAIT on the edge where imem_req&imem_ready=1, else stay in REQ.
REQ-019 In WAIT: imem_req=0; on imem_valid=1 the block SHALL latch imem_data into instruction and move to EXEC.
REQ-020 imem_valid SHALL be ignored in REQ and EXEC.
REQ-021 In EXEC: instr_valid=1; ps, k, reg_a, ns and stall SHALL be sampled only in EXEC.
REQ-022 EXEC with stall=1 SHALL hold state, PC and instruction unchanged; stall takes priority over ns.
REQ-023 EXEC with stall=0 and ns=1 SHALL set an internal second-cycle flag and stay in EXEC; PC is unchanged.
REQ-024 EXEC with stall=0 and the second-cycle flag set SHALL treat ns as 0, so each instruction gets at most two execute cycles.
REQ-025 EXEC with stall=0 and ns=0 (or the flag set) SHALL: update the PC, clear the flag, increment retired, and move to REQ.
REQ-026 PC update by ps: 00 or 01 -> pc+4; 10 -> reg_a; 11 -> pc+(k<<2).
REQ-027 All PC arithmetic SHALL be modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC+4 SHALL give 0.
REQ-028 pc_plus4 SHALL be combinational from pc.
REQ-029 Minimum fetch-to-execute latency SHALL be 2 cycles (REQ, then WAIT with imem_valid=1); there is no upper bound.
REQ-030 imem_addr[1:0] SHALL always equal pc[1:0]; misalignment is not checked.
REQ-031 retired SHALL wrap to 0 after all-ones.

Reset
REQ-032 Asserting reset SHALL immediately force: state=REQ, pc=RESET_PC, instruction=0, flag=0, retired=0, instr_valid=0.
REQ-033 Reset in any state, including mid-WAIT, SHALL abandon the outstanding fetch; the first post-reset request SHALL be at RESET_PC.
REQ-034 imem_req SHALL be 0 while reset is asserted, then assert in the first cycle after release.

Structure
REQ-035 The PS encodings, the FSM state enum and the width constant 64 SHALL live in the shared CPU package used by the control unit.
REQ-036 The next-PC computation (REQ-026/027) SHALL be one sub-module, next_pc_logic; the FSM, registers and counter stay in fetch_unit.

Verification
REQ-037 Reset release, imem_ready=1, imem_valid one cycle later with data 32'h8B020020 -> imem_addr=0, instr_valid asserts 2 cycles after release, instruction=32'h8B020020.
REQ-038 Sequential run, ps=01, 3 instructions -> fetch addresses 0,4,8; retired=3.
REQ-039 At pc=16, ps=11, k=64'hFFFF_FFFF_FFFF_FFFE -> next fetch at 8; ps=10 with reg_a=64'h100 -> next fetch at 64'h100.
REQ-040 EXEC with ns=1 for one cycle, then 0 -> instr_valid high for 2 cycles, PC unchanged between them, retired increments once; ns held at 1 -> still exactly 2 cycles.
REQ-041 stall=1 for 3 cycles in EXEC, with ns=1 in the first stalled cycle -> instr_valid high 4 cycles, single retire, no second-cycle extension.
REQ-042 Reset asserted in WAIT, then imem_valid pulses -> response ignored, state=REQ, next imem_addr=RESET_PC; pc=64'hFFFF_FFFF_FFFF_FFFC, ps=01 -> next fetch at 0.
